// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite initiator: valid/ready request in, NONSEQ SINGLE on the bus, registered response out.
// Optional wait-state timeout is enabled by defining AHB_MASTER_TIMEOUT_EN.
module ahb_lite_master #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              resp_timeout,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              illegal_c;

`ifdef AHB_MASTER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            resp_timeout_q, resp_timeout_d;
`endif

    // Requests the bus cannot express: oversize or not naturally aligned.
    always_comb begin
        illegal_c = (req_size > 3'd2)
                 || ((req_size == 3'd1) && req_addr[0])
                 || ((req_size == 3'd2) && (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        htrans_d     = htrans_q;
        haddr_d      = haddr_q;
        hwrite_d     = hwrite_q;
        hsize_d      = hsize_q;
        hwdata_d     = hwdata_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
        to_cnt_d       = to_cnt_q;
        resp_timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (illegal_c) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d  = S_ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = req_addr;
                        hwrite_d = req_write;
                        hsize_d  = req_size;
                        wdata_d  = req_wdata;
`ifdef AHB_MASTER_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    state_d  = S_DATA;
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = hwrite_q ? wdata_q : '0;
                end
            end
            S_DATA: begin
                // First cycle of a two-cycle ERROR is just another wait state here.
                if (HREADY) begin
                    state_d      = S_RESP;
                    hwdata_d     = '0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = hwrite_q ? '0 : HRDATA;
                    resp_err_d   = HRESP;
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef AHB_MASTER_TIMEOUT_EN
        // Wait states in either phase accumulate toward the abort threshold.
        if (((state_q == S_ADDR) || (state_q == S_DATA)) && !HREADY) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d        = S_RESP;
                htrans_d       = HTRANS_IDLE;
                hwdata_d       = '0;
                resp_valid_d   = 1'b1;
                resp_err_d     = 1'b1;
                resp_timeout_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            htrans_q     <= HTRANS_IDLE;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
            hsize_q      <= 3'd0;
            hwdata_q     <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
            to_cnt_q       <= '0;
            resp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            htrans_q     <= htrans_d;
            haddr_q      <= haddr_d;
            hwrite_q     <= hwrite_d;
            hsize_q      <= hsize_d;
            hwdata_q     <= hwdata_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
`ifdef AHB_MASTER_TIMEOUT_EN
            to_cnt_q       <= to_cnt_d;
            resp_timeout_q <= resp_timeout_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
`ifdef AHB_MASTER_TIMEOUT_EN
    assign resp_timeout = resp_timeout_q;
`else
    assign resp_timeout = 1'b0;
`endif
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomized bench for ahb_lite_master; a cycle-level transaction model predicts every bus and response value.
module tb_ahb_lite_master;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TO     = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_size;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid, resp_err, resp_timeout;
    logic [DATA_W-1:0] resp_rdata;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]        HSIZE, HBURST;
    logic [3:0]        HPROT;
    logic [DATA_W-1:0] HWDATA, HRDATA;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    ahb_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_timeout(resp_timeout),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_illegal(input logic [2:0] size, input logic [31:0] addr);
        return (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
    endfunction

    // One transfer: wa address-phase waits, wd data-phase waits, slave error flag, slave read data.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wd, input int wa, input int wdw,
                           input logic err, input logic [31:0] rd);
        logic ill;
        int   last;
        ill  = is_illegal(size, addr);
        last = wa + wdw + 3;
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 32'd1);
        chk("htrans_idle", 32'(HTRANS), 32'd0);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size; req_wdata = wd;
        HREADY = 1'b1; HRESP = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 3'($urandom);
        if (ill) begin
            chk("ill_resp_valid", 32'(resp_valid), 32'd1);
            chk("ill_resp_err", 32'(resp_err), 32'd1);
            chk("ill_htrans", 32'(HTRANS), 32'd0);
            chk("ill_ready_low", 32'(req_ready), 32'd0);
            @(negedge clk);
            chk("ill_resp_drop", 32'(resp_valid), 32'd0);
            chk("ill_ready_back", 32'(req_ready), 32'd1);
            chk("ill_htrans2", 32'(HTRANS), 32'd0);
            return;
        end
        for (int k = 1; k <= last; k++) begin
            if (k <= wa + 1) begin
                chk("addr_htrans", 32'(HTRANS), 32'd2);
                chk("addr_haddr", HADDR, addr);
                chk("addr_hwrite", 32'(HWRITE), 32'(wr));
                chk("addr_hsize", 32'(HSIZE), 32'(size));
                chk("addr_no_resp", 32'(resp_valid), 32'd0);
                HREADY = (k == wa + 1);
                HRESP  = 1'b0;
                HRDATA = $urandom;
            end else if (k < last) begin
                chk("data_htrans", 32'(HTRANS), 32'd0);
                chk("data_hwdata", HWDATA, wr ? wd : 32'd0);
                chk("data_no_resp", 32'(resp_valid), 32'd0);
                HREADY = (k == last - 1);
                HRESP  = err && (k >= last - 2);
                HRDATA = (k == last - 1) ? rd : $urandom;
            end else begin
                chk("resp_valid", 32'(resp_valid), 32'd1);
                chk("resp_rdata", resp_rdata, wr ? 32'd0 : rd);
                chk("resp_err", 32'(resp_err), 32'(err));
                chk("resp_timeout", 32'(resp_timeout), 32'd0);
                chk("resp_ready_low", 32'(req_ready), 32'd0);
                chk("resp_htrans", 32'(HTRANS), 32'd0);
                HREADY = 1'b1; HRESP = 1'b0;
            end
            @(negedge clk);
        end
        chk("post_resp_drop", 32'(resp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic        wr;
        logic [31:0] a, d, r;
        logic [2:0]  sz;
        int          sel, wa, wdw;
        logic        e;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
        req_wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("const_hburst", 32'(HBURST), 32'd0);
        chk("const_hprot", 32'(HPROT), 32'd3);
        chk("const_lock", 32'(HMASTLOCK), 32'd0);
        rst = 1'b0;

        // Directed cases
        run_txn(1'b1, 32'h8005_0000, 3'd2, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0);
        run_txn(1'b0, 32'h8005_0004, 3'd2, 32'h0, 0, 2, 1'b0, 32'h1234_5678);
        run_txn(1'b0, 32'h8005_0010, 3'd2, 32'h0, 0, 1, 1'b1, 32'hAAAA_5555);
        run_txn(1'b0, 32'h8005_0002, 3'd2, 32'h0, 0, 0, 1'b0, 32'h0);
        run_txn(1'b0, 32'h8005_0000, 3'd3, 32'h0, 0, 0, 1'b0, 32'h0);
        run_txn(1'b0, 32'h8005_0001, 3'd1, 32'h0, 0, 0, 1'b0, 32'h0);
        run_txn(1'b0, 32'h8005_0003, 3'd0, 32'h0, 1, 1, 1'b0, 32'h0000_00A5);

        // Reset during the data phase of a write
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8005_0020; req_size = 3'd2;
        req_wdata = 32'hCAFE_F00D; HREADY = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstd_addr_htrans", 32'(HTRANS), 32'd2);
        @(negedge clk);
        chk("rstd_data_hwdata", HWDATA, 32'hCAFE_F00D);
        HREADY = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rstd_htrans", 32'(HTRANS), 32'd0);
        chk("rstd_hwdata", HWDATA, 32'd0);
        chk("rstd_resp_valid", 32'(resp_valid), 32'd0);
        chk("rstd_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0; HREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstd_no_resp", 32'(resp_valid), 32'd0);
            chk("rstd_idle_ready", 32'(req_ready), 32'd1);
        end
        run_txn(1'b0, 32'h8005_0024, 3'd2, 32'h0, 0, 0, 1'b0, 32'h0BAD_CAFE);

        // Slave stalls the data phase forever
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8005_0030; req_size = 3'd2;
        HREADY = 1'b1; HRESP = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("to_addr_htrans", 32'(HTRANS), 32'd2);
        HREADY = 1'b1;
        @(negedge clk);
`ifdef AHB_MASTER_TIMEOUT_EN
        for (int i = 0; i < int'(TO); i++) begin
            chk("to_wait_no_resp", 32'(resp_valid), 32'd0);
            HREADY = 1'b0;
            @(negedge clk);
        end
        chk("to_resp_valid", 32'(resp_valid), 32'd1);
        chk("to_resp_err", 32'(resp_err), 32'd1);
        chk("to_resp_timeout", 32'(resp_timeout), 32'd1);
        chk("to_htrans", 32'(HTRANS), 32'd0);
        HREADY = 1'b1;
        @(negedge clk);
        chk("to_ready_back", 32'(req_ready), 32'd1);
`else
        for (int i = 0; i < 40; i++) begin
            chk("stall_no_resp", 32'(resp_valid), 32'd0);
            chk("stall_no_timeout", 32'(resp_timeout), 32'd0);
            HREADY = 1'b0;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; HREADY = 1'b1;
        @(negedge clk);
        chk("stall_ready_back", 32'(req_ready), 32'd1);
`endif

        // Randomized transfers
        for (int n = 0; n < 60; n++) begin
            wr  = 1'($urandom_range(0, 1));
            a   = $urandom;
            d   = $urandom;
            r   = $urandom;
            sz  = 3'($urandom_range(0, 2));
            sel = $urandom_range(0, 9);
            if (sel < 7) a = (sz == 3'd2) ? {a[31:2], 2'b00} : (sz == 3'd1) ? {a[31:1], 1'b0} : a;
            if (sel == 9) sz = 3'($urandom_range(3, 7));
            wa  = $urandom_range(0, 2);
            wdw = $urandom_range(0, 3);
            e   = ($urandom_range(0, 4) == 0);
            if (e && wdw == 0) wdw = 1;
            run_txn(wr, a, sz, d, wa, wdw, e, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Single-transfer AHB-Lite initiator that converts a simple valid/ready request port into AHB-Lite address and data phases.
- Intended clients are peripherals that need to drive the bus directly, such as a DMA-style engine or a debug or boot loader. It is the initiating end of the same bus that the slave wrappers (CLINT and others) respond on.
- Issues one NONSEQ SINGLE transfer per request and returns read data or error on a registered response port.

Parameters:
- ADDR_W, 32, address width of req_addr and HADDR.
- DATA_W, 32, data width of wdata, rdata, HWDATA and HRDATA.
- TIMEOUT_CYCLES, 256, wait-state limit; used only when AHB_MASTER_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  client request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  byte address.
- req_size  input  3  HSIZE encoding: 0 = byte, 1 = half, 2 = word.
- req_wdata  input  DATA_W  write data.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  DATA_W  read data, valid with resp_valid.
- resp_err  output  1  transfer failed (HRESP error, misaligned or illegal size, or timeout).
- resp_timeout  output  1  failure was caused by timeout.
- HADDR  output  ADDR_W  AHB address.
- HTRANS  output  2  AHB transfer type.
- HWRITE  output  1  AHB write.
- HSIZE  output  3  AHB size.
- HBURST  output  3  constant 3'b000 (SINGLE).
- HPROT  output  4  constant 4'b0011.
- HMASTLOCK  output  1  constant 0.
- HWDATA  output  DATA_W  AHB write data.
- HRDATA  input  DATA_W  AHB read data.
- HREADY  input  1  AHB ready.
- HRESP  input  1  AHB response; 1 = ERROR.

Behaviour:
- Reset:
  - State returns to IDLE.
  - HTRANS = 2'b00; HADDR, HWRITE, HSIZE and HWDATA = 0.
  - resp_valid, resp_err and resp_timeout = 0; resp_rdata = 0.
  - req_ready = 1 as soon as reset is released.
- States are IDLE, ADDR, DATA and RESP.
- IDLE:
  - req_ready = 1 and HTRANS = IDLE.
  - A request is accepted on a posedge with req_valid & req_ready, and write, addr, size and wdata are latched at that edge.
  - An illegal request goes to RESP with err = 1, and no bus activity occurs. Illegal means req_size > 2, or size 1 with addr[0] != 0, or size 2 with addr[1:0] != 0.
  - Otherwise the block goes to ADDR.
- ADDR:
  - Drives HTRANS = 2'b10 (NONSEQ) with the latched HADDR, HWRITE and HSIZE.
  - Holds all of these while HREADY = 0.
  - On a posedge with HREADY = 1, goes to DATA.
- DATA:
  - Drives HTRANS = 2'b00.
  - HWDATA = latched wdata for writes and 0 for reads.
  - HWDATA is held stable for the entire data phase.
  - On a posedge with HREADY = 1, captures HRDATA (reads only; writes capture 0), captures err = HRESP, and goes to RESP.
  - The first cycle of the two-cycle ERROR response (HRESP = 1, HREADY = 0) is treated as a wait state. No new transfer is issued, so no cancellation is needed.
- RESP:
  - resp_valid = 1 for exactly one cycle, with resp_rdata and resp_err.
  - Next state is IDLE.
- req_ready = 0 in ADDR, DATA and RESP. Requests are never dropped; the client holds req_valid.
- Latency with zero wait states:
  - Accept at edge 0; address phase in cycle 1; data phase in cycle 2; resp_valid high in cycle 3.
  - Each wait state adds one cycle.
  - Maximum throughput is one transfer per 4 cycles.
- resp_rdata holds its last value between responses.
- An asynchronous reset in any state aborts the transfer and forces the outputs to their reset values. The in-flight request produces no response.

Optional Feature:
- Macro: AHB_MASTER_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to ADDR.
  - It increments on each cycle in ADDR or DATA with HREADY = 0.
  - When it reaches TIMEOUT_CYCLES, the block drives HTRANS = IDLE, goes to RESP, and reports resp_err = 1 and resp_timeout = 1.
  - Counter width is $clog2(TIMEOUT_CYCLES + 1).
- When not defined:
  - The block waits indefinitely.
  - resp_timeout is tied to 0 and no counter is instantiated.

Test Plan:
- Word write, addr 0x80050000, wdata 0xDEADBEEF, HREADY always 1 -> NONSEQ in cycle 1 with HWRITE = 1, HSIZE = 2; HWDATA = 0xDEADBEEF in cycle 2; resp_valid in cycle 3 with err = 0.
- Word read, addr 0x80050004, slave returns 0x12345678 after 2 wait states -> HTRANS and HADDR held throughout; resp_valid in cycle 5 with rdata = 0x12345678, err = 0.
- Read addr 0x80050010; slave gives HRESP = 1 with HREADY = 0, then HRESP = 1 with HREADY = 1 -> no second NONSEQ issued; resp_valid with resp_err = 1.
- Misaligned word read at addr 0x80050002, and separately req_size = 3 -> HTRANS stays IDLE; resp_valid one cycle after accept with err = 1.
- Assert rst during DATA of a write -> HTRANS = 0, resp_valid = 0, req_ready = 1 after release; a following read completes normally.
- With AHB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, HREADY held at 0 in DATA -> after 8 wait cycles, resp_valid with err = 1 and timeout = 1. Without the macro, no response ever occurs.
